// File: rtl/lsu_byte_master.sv
// ============================================================================
// Module   : lsu_byte_master
// Function : Load/store initiator sequencing one byte per cycle on a big-endian
//            byte-wide memory port, with sign/zero extension of load results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_byte_master #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_func3;
  logic [1:0]  r_k;
  logic [1:0]  r_last;
  logic [23:0] r_acc;
  logic [31:0] r_sh;

  logic        w_accept;
  logic [1:0]  w_last;
  logic [4:0]  w_sh_amt;
  logic        w_bad_func;
  logic [32:0] w_end;
  logic        w_oob;
  logic [31:0] w_wshift;
  logic [31:0] w_acc_next;
  logic [31:0] w_load_data;

  // Ready is held low for the whole time reset is asserted.
  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_last   = 2'd3;
    w_sh_amt = 5'd0;
    case (req_func3[1:0])
      2'b00:   begin w_last = 2'd0; w_sh_amt = 5'd24; end
      2'b01:   begin w_last = 2'd1; w_sh_amt = 5'd16; end
      default: ;
    endcase
  end

  assign w_bad_func = req_we ? (req_func3 > 3'b010)
                             : ((req_func3[1:0] == 2'b11) || (req_func3[2:1] == 2'b11));
  // Last byte address at 33 bits so a high address cannot wrap into range.
  assign w_end      = {1'b0, req_addr} + {31'd0, w_last};
  assign w_oob      = w_end >= 33'(MEM_BYTES);
  // Left-justify the store bytes so the MSB-first byte is always [31:24].
  assign w_wshift   = req_wdata << w_sh_amt;
  assign w_acc_next = {r_acc, mem_rdata};

  always_comb begin
    w_load_data = w_acc_next;
    case (r_func3)
      3'b000:  w_load_data = {{24{w_acc_next[7]}}, w_acc_next[7:0]};
      3'b100:  w_load_data = {24'd0, w_acc_next[7:0]};
      3'b001:  w_load_data = {{16{w_acc_next[15]}}, w_acc_next[15:0]};
      3'b101:  w_load_data = {16'd0, w_acc_next[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_func3   <= 3'd0;
      r_k       <= 2'd0;
      r_last    <= 2'd0;
      r_acc     <= 24'd0;
      r_sh      <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      mem_addr  <= 32'd0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_func3 <= req_func3;
            r_k     <= 2'd0;
            r_last  <= w_last;
            r_acc   <= 24'd0;
            if (w_bad_func || w_oob) begin
              r_state   <= ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              r_state   <= XFER;
              mem_addr  <= req_addr;
              mem_re    <= !req_we;
              mem_we    <= req_we;
              mem_wdata <= req_we ? w_wshift[31:24] : 8'd0;
              r_sh      <= w_wshift << 8;
            end
          end
        end
        XFER: begin
          if (!r_we) begin
            r_acc <= w_acc_next[23:0];
          end
          if (r_k == r_last) begin
            r_state   <= RESP;
            mem_addr  <= 32'd0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'd0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_we ? 32'd0 : w_load_data;
          end else begin
            r_k       <= r_k + 2'd1;
            mem_addr  <= mem_addr + 32'd1;
            mem_wdata <= r_we ? r_sh[31:24] : 8'd0;
            r_sh      <= r_sh << 8;
          end
        end
        RESP, ERR: begin
          r_state   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_master.sv
// ============================================================================
// Module   : tb_lsu_byte_master
// Function : Directed bench for lsu_byte_master with a byte memory model and a
//            response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_byte_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  lsu_byte_master #(.MEM_BYTES(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we && (mem_addr < 32'd256)) mem[mem_addr[7:0]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every response is checked against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_rdata", rsp_rdata, e.data);
        check("rsp_cycle", 32'(cyc), 32'(e.at));
        check("rsp_no_strobe", {30'd0, mem_re, mem_we}, 32'd0);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err,
                       input logic [31:0] exp_data, input int lat);
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wd;
    e.err  = exp_err;
    e.data = exp_data;
    e.at   = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    mem[8'h10] <= 8'h80;
    mem[8'h11] <= 8'h12;
    mem[8'h12] <= 8'h34;
    mem[8'h13] <= 8'h56;

    #1 rst_n = 1'b0;
    #2;
    check("reset_ctrl", {27'd0, req_ready, rsp_valid, rsp_err, mem_re, mem_we}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_mem_port", mem_addr | {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Word load: four read strobes at ascending addresses, then the response.
    issue(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'h80123456, 5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lw_strobes", {30'd0, mem_re, mem_we}, 32'd2);
      check("lw_addr", mem_addr, 32'h10 + 32'(k));
    end
    @(negedge clk);
    check("lw_idle_port", {31'd0, mem_re} | mem_addr, 32'd0);
    drain();

    issue(1'b0, 3'b000, 32'h10, 32'd0, 1'b0, 32'hFFFFFF80, 2);
    drain();
    issue(1'b0, 3'b100, 32'h10, 32'd0, 1'b0, 32'h00000080, 2);
    drain();
    issue(1'b0, 3'b001, 32'h10, 32'd0, 1'b0, 32'hFFFF8012, 3);
    drain();
    issue(1'b0, 3'b101, 32'h11, 32'd0, 1'b0, 32'h00001234, 3);
    drain();
    issue(1'b0, 3'b010, 32'hFC, 32'd0, 1'b0, 32'hA6A7A4A5, 5);
    drain();

    issue(1'b1, 3'b001, 32'h20, 32'hAAAA1234, 1'b0, 32'd0, 3);
    drain();
    check("sh_mem20", {24'd0, mem[8'h20]}, 32'h12);
    check("sh_mem21", {24'd0, mem[8'h21]}, 32'h34);
    check("sh_mem22", {24'd0, mem[8'h22]}, 32'h78);

    issue(1'b0, 3'b010, 32'hFE, 32'd0, 1'b1, 32'd0, 1);
    drain();
    issue(1'b1, 3'b011, 32'h00, 32'h12345678, 1'b1, 32'd0, 1);
    drain();
    issue(1'b0, 3'b111, 32'h00, 32'd0, 1'b1, 32'd0, 1);
    drain();

    // Word store cut short by reset during its third byte.
    issue(1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 1'b0, 32'd0, 5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst_mid_ctrl", {27'd0, req_ready, rsp_valid, rsp_err, mem_re, mem_we}, 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    check("rst_mid_mem_port", mem_addr | {24'd0, mem_wdata}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst_mid", {31'd0, req_ready}, 32'd1);
    check("sw_mem30", {24'd0, mem[8'h30]}, 32'hDE);
    check("sw_mem31", {24'd0, mem[8'h31]}, 32'hAD);
    check("sw_mem32", {24'd0, mem[8'h32]}, 32'h68);
    check("sw_mem33", {24'd0, mem[8'h33]}, 32'h69);

    // Back-to-back: valid stays high, second request waits for the unit.
    begin
      int   c0;
      exp_t e;
      @(negedge clk);
      c0 = cyc;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_func3 = 3'b000;
      req_addr  = 32'h40;
      req_wdata = 32'h00000077;
      e.err = 1'b0; e.data = 32'd0; e.at = c0 + 2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_we    = 1'b0;
      req_func3 = 3'b010;
      req_addr  = 32'h10;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (req_ready) break;
      end
      check("b2b_accept_gap", 32'(cyc - c0), 32'd3);
      e.err = 1'b0; e.data = 32'h80123456; e.at = cyc + 5;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
    drain();
    check("sb_mem40", {24'd0, mem[8'h40]}, 32'h77);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
